// File: rtl/core_dmem_resp_pkg.sv
// Shared encodings for the data-memory responder: funct3 load/store codes,
// FSM state encoding and the latched request record.
package core_dmem_resp_pkg;

    localparam logic [2:0] FUNC_B  = 3'b000;   // LB / SB
    localparam logic [2:0] FUNC_H  = 3'b001;   // LH / SH
    localparam logic [2:0] FUNC_W  = 3'b010;   // LW / SW
    localparam logic [2:0] FUNC_BU = 3'b100;   // LBU (loads only)
    localparam logic [2:0] FUNC_HU = 3'b101;   // LHU (loads only)

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  func;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/core_dmem_resp_lane.sv
// Byte-lane steering for one access: byte enables, store-data replication,
// load extraction with sign/zero extension, and func/alignment checking.
module dmem_lane
    import core_dmem_resp_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  func,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        err
);

    logic [31:0] shifted;

    always_comb begin
        be      = 4'b0000;
        wword   = wdata;
        ldata   = '0;
        err     = 1'b0;
        shifted = rword >> {addr_lo, 3'b000};
        case (func)
            FUNC_B: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                ldata = {{24{shifted[7]}}, shifted[7:0]};
            end
            FUNC_H: begin
                err   = addr_lo[0];
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wword = {2{wdata[15:0]}};
                ldata = {{16{shifted[15]}}, shifted[15:0]};
            end
            FUNC_W: begin
                err   = |addr_lo;
                be    = 4'b1111;
                ldata = rword;
            end
            FUNC_BU: begin
                err   = is_store;
                ldata = {24'b0, shifted[7:0]};
            end
            FUNC_HU: begin
                err   = is_store | addr_lo[0];
                ldata = {16'b0, shifted[15:0]};
            end
            default: err = 1'b1;
        endcase
        // Suppressed accesses neither write nor return data.
        if (err || !is_store) be = 4'b0000;
        if (err) ldata = '0;
    end

endmodule

// File: rtl/core_dmem_resp.sv
// Multi-cycle MEM-stage data memory: IDLE/BUSY/DONE handshake with a
// combinational pipeline stall and registered load data / error pulses.
module core_dmem_resp
    import core_dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  func_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    dmem_state_e state, state_n;
    logic [3:0]  cnt;
    dmem_req_t   req_q, cur;
    logic        req_in, commit;
    logic [AW-1:0] widx;
    logic [31:0] mem [DEPTH_WORDS];
    logic [3:0]  be;
    logic [31:0] wword, ldata;
    logic        err;
    logic        addr_unused;

    assign req_in = memread_i | memwrite_i;

    // In IDLE the live inputs drive the datapath so LATENCY=0 can commit
    // on the acceptance edge; afterwards the latched copy is used.
    always_comb begin
        cur = req_q;
        if (state == DMEM_IDLE) begin
            cur.is_store = memwrite_i;
            cur.func     = func_i;
            cur.addr     = addr_i;
            cur.wdata    = wdata_i;
        end
    end

    assign widx        = cur.addr[AW+1:2];
    assign addr_unused = ^{cur.addr[31:AW+2]};

    dmem_lane u_lane (
        .is_store (cur.is_store),
        .func     (cur.func),
        .addr_lo  (cur.addr[1:0]),
        .wdata    (cur.wdata),
        .rword    (mem[widx]),
        .be       (be),
        .wword    (wword),
        .ldata    (ldata),
        .err      (err)
    );

    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        commit  = 1'b0;
        case (state)
            DMEM_IDLE: if (req_in) begin
                stall_o = 1'b1;
                if (LAT4 == 4'd0) begin
                    state_n = DMEM_DONE;
                    commit  = 1'b1;
                end else begin
                    state_n = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                stall_o = 1'b1;
                if (cnt == 4'd1) begin
                    state_n = DMEM_DONE;
                    commit  = 1'b1;
                end
            end
            // Requests still held during DONE are deliberately ignored.
            DMEM_DONE: state_n = DMEM_IDLE;
            default:   state_n = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DMEM_IDLE;
            cnt   <= 4'd0;
            req_q <= '0;
        end else begin
            state <= state_n;
            if (state == DMEM_IDLE && req_in) begin
                cnt   <= LAT4;
                req_q <= cur;
            end else if (state == DMEM_BUSY) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= commit & ~cur.is_store & ~err;
            err_o    <= commit & err;
            if (commit && (err || !cur.is_store)) rdata_o <= ldata;
        end
    end

    // Storage is not reset; an async reset clears commit before this edge.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (commit && be[k]) mem[widx][8*k +: 8] <= wword[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_core_dmem_resp.sv
// Directed bench for core_dmem_resp with a byte-array memory model and a
// per-cycle expected-output compare.
module tb_core_dmem_resp;

    localparam int LAT = 2;
    localparam int DW  = 256;
    localparam int NB  = DW * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memread_i = 1'b0, memwrite_i = 1'b0;
    logic [2:0]  func_i = 3'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [31:0] rdata_o;
    logic        rvalid_o, err_o, stall_o;

    core_dmem_resp #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memread_i  (memread_i),
        .memwrite_i (memwrite_i),
        .func_i     (func_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .err_o      (err_o),
        .stall_o    (stall_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;
    logic        exp_stall = 1'b0, exp_rvalid = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    byte unsigned mb [NB];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit model_err(input bit st, input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'd0:       return 1'b0;
            3'd1:       return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            3'd4, 3'd5: return st;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
        int unsigned base, b0, b1, b2, b3, h;
        base = a % NB;
        b0 = mb[base];
        b1 = mb[(base + 1) % NB];
        b2 = mb[(base + 2) % NB];
        b3 = mb[(base + 3) % NB];
        h  = b0 + 256 * b1;
        case (f)
            3'd0:    return (b0 >= 128) ? 32'(b0) + 32'hFFFF_FF00 : 32'(b0);
            3'd4:    return 32'(b0);
            3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            3'd5:    return 32'(h);
            default: return 32'(b0 + 256 * b1 + 65536 * b2 + 16777216 * b3);
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[(a + i) % NB] = 8'(wd >> (8 * i));
    endtask

    // Per-cycle check of every output against the model's expectation.
    always @(negedge clk) begin
        if (checking) begin
            chk("stall_o",  32'(stall_o),  32'(exp_stall));
            chk("rvalid_o", 32'(rvalid_o), 32'(exp_rvalid));
            chk("err_o",    32'(err_o),    32'(exp_err));
            chk("rdata_o",  rdata_o,       exp_rdata);
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        memread_i = 1'b0; memwrite_i = 1'b0;
        exp_stall = 1'b0; exp_rvalid = 1'b0; exp_err = 1'b0;
    endtask

    // One access from acceptance through DONE; ends inside the DONE cycle.
    task automatic access(input bit st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold,
                          input bit pin_en, input logic [31:0] pin_val);
        bit e;
        @(posedge clk); #1;
        memwrite_i = st; memread_i = !st; func_i = f; addr_i = a; wdata_i = wd;
        exp_stall = 1'b1; exp_rvalid = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk); #1;
            if (!hold) begin
                memread_i = 1'b0; memwrite_i = 1'b0;
                addr_i = $urandom; wdata_i = $urandom; func_i = 3'($urandom);
            end
        end
        @(posedge clk); #1;
        e = model_err(st, f, a);
        exp_stall  = 1'b0;
        exp_err    = e;
        exp_rvalid = !st && !e;
        if (e)        exp_rdata = '0;
        else if (st)  model_store(f, a, wd);
        else          exp_rdata = model_load(f, a);
        if (pin_en) chk("pinned rdata", rdata_o, pin_val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        // word store/load and narrow extensions
        access(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, 0);   idle();
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'hDEADBEEF);   idle();
        access(0, 3'd0, 32'h13, 0, 0, 1, 32'hFFFFFFDE);   idle();
        access(0, 3'd4, 32'h13, 0, 0, 1, 32'h000000DE);   idle();
        access(0, 3'd1, 32'h12, 0, 0, 1, 32'hFFFFDEAD);   idle();
        access(0, 3'd5, 32'h12, 0, 0, 1, 32'h0000DEAD);   idle();

        // sub-word stores, back-to-back with the following load
        access(1, 3'd0, 32'h11, 32'h12345655, 0, 0, 0);
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'hDEAD55EF);   idle();
        access(1, 3'd1, 32'h12, 32'hAAAA1234, 0, 0, 0);
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'h123455EF);   idle();

        // error cases
        access(0, 3'd2, 32'h12, 0, 0, 1, 32'h0);          idle();
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'h123455EF);   idle();
        access(1, 3'd1, 32'h11, 32'hFFFFFFFF, 0, 1, 32'h0); idle();
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'h123455EF);   idle();
        access(0, 3'd3, 32'h10, 0, 0, 1, 32'h0);          idle();
        access(1, 3'd4, 32'h10, 32'h0, 0, 0, 0);          idle();
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'h123455EF);   idle();

        // request held through DONE, then an aliased address
        access(0, 3'd2, 32'h10, 0, 1, 1, 32'h123455EF);
        access(0, 3'd2, 32'h410, 0, 0, 1, 32'h123455EF);  idle();

        // reset during BUSY aborts the store
        @(posedge clk); #1;
        memwrite_i = 1'b1; memread_i = 1'b0; func_i = 3'd2; addr_i = 32'h10; wdata_i = 32'h0;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        memwrite_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_stall = 1'b0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        chk("reset stall_o",  32'(stall_o),  32'h0);
        chk("reset rvalid_o", 32'(rvalid_o), 32'h0);
        chk("reset err_o",    32'(err_o),    32'h0);
        chk("reset rdata_o",  rdata_o,       32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle();
        access(0, 3'd2, 32'h10, 0, 0, 1, 32'h123455EF);   idle();
        idle();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
